// File: rtl/jtag_shift_engine.sv
// JTAG shift engine: clocks up to MAX_BITS TMS/TDI bits out on a divided TCK and captures TDO.
// Optional macro JTAG_SHIFT_TRST_EN adds a cmd_trst command that pulses jtag_TRSTn low.
module jtag_shift_engine #(
    parameter  int MAX_BITS   = 32,
    parameter  int DIV_W      = 8,
    parameter  int NUM_CHAINS = 1,
    localparam int CHAIN_W    = (NUM_CHAINS > 1) ? $clog2(NUM_CHAINS) : 1,
    localparam int LEN_W      = $clog2(MAX_BITS + 1)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [DIV_W-1:0]      cfg_div,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [MAX_BITS-1:0]   cmd_tms,
    input  logic [MAX_BITS-1:0]   cmd_tdi,
    input  logic [CHAIN_W-1:0]    cmd_chain,
`ifdef JTAG_SHIFT_TRST_EN
    input  logic                  cmd_trst,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [MAX_BITS-1:0]   rsp_tdo,
    output logic                  rsp_undriven,
    output logic                  jtag_TCK,
    output logic                  jtag_TMS,
    output logic                  jtag_TDI,
    output logic                  jtag_TRSTn,
    input  logic [NUM_CHAINS-1:0] jtag_TDO_data,
    input  logic [NUM_CHAINS-1:0] jtag_TDO_driven,
    output logic                  busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_RESP
`ifdef JTAG_SHIFT_TRST_EN
        , ST_TRST
`endif
    } state_e;

    state_e              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [LEN_W-1:0]    rem_q;
    logic [CHAIN_W-1:0]  chain_q;
    logic [MAX_BITS-1:0] tms_sh_q;
    logic [MAX_BITS-1:0] tdi_sh_q;
    logic [MAX_BITS-1:0] mask_q;
    logic [MAX_BITS-1:0] rsp_tdo_q;
    logic                rsp_undriven_q;
    logic                rsp_valid_q;
    logic                cmd_ready_q;
    logic                tck_q;
    logic                tms_q;
    logic                tdi_q;
`ifdef JTAG_SHIFT_TRST_EN
    logic                trstn_q;
    logic                half_q;
`endif

    logic                tdo_bit;
    logic                tdo_drv;
    logic                half_done;
    logic [LEN_W-1:0]    len_clamped;
    logic [MAX_BITS-1:0] tms_shr;
    logic [MAX_BITS-1:0] tdi_shr;

    // Out-of-range chain selects match no entry and therefore read as undriven.
    always_comb begin
        tdo_bit = 1'b0;
        tdo_drv = 1'b0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            if (chain_q == CHAIN_W'(c)) begin
                tdo_drv = jtag_TDO_driven[c];
                tdo_bit = jtag_TDO_data[c];
            end
        end
    end

    assign half_done   = (cnt_q == div_q);
    assign len_clamped = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
    assign tms_shr     = tms_sh_q >> 1;
    assign tdi_shr     = tdi_sh_q >> 1;

    // NOTE: every state and output register uses <= so all of them see pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            div_q          <= '0;
            cnt_q          <= '0;
            rem_q          <= '0;
            chain_q        <= '0;
            tms_sh_q       <= '0;
            tdi_sh_q       <= '0;
            mask_q         <= '0;
            rsp_tdo_q      <= '0;
            rsp_undriven_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            cmd_ready_q    <= 1'b0;
            tck_q          <= 1'b0;
            tms_q          <= 1'b1;
            tdi_q          <= 1'b0;
`ifdef JTAG_SHIFT_TRST_EN
            trstn_q        <= 1'b1;
            half_q         <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_valid && cmd_ready_q) begin
                        cmd_ready_q    <= 1'b0;
                        div_q          <= cfg_div;
                        cnt_q          <= '0;
                        chain_q        <= cmd_chain;
                        tms_sh_q       <= cmd_tms;
                        tdi_sh_q       <= cmd_tdi;
                        mask_q         <= MAX_BITS'(1);
                        rsp_tdo_q      <= '0;
                        rsp_undriven_q <= 1'b0;
                        rem_q          <= len_clamped;
`ifdef JTAG_SHIFT_TRST_EN
                        if (cmd_trst) begin
                            state_q <= ST_TRST;
                            trstn_q <= 1'b0;
                            tms_q   <= 1'b1;
                            half_q  <= 1'b0;
                            rem_q   <= (len_clamped == '0) ? LEN_W'(1) : len_clamped;
                        end else
`endif
                        if (len_clamped == '0) begin
                            state_q <= ST_RESP;
                        end else begin
                            state_q <= ST_LOW;
                            tms_q   <= cmd_tms[0];
                            tdi_q   <= cmd_tdi[0];
                        end
                    end
                end
                ST_LOW: begin
                    if (half_done) begin
                        cnt_q   <= '0;
                        tck_q   <= 1'b1;
                        state_q <= ST_HIGH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (cnt_q == '0) begin
                        rsp_tdo_q <= rsp_tdo_q | (mask_q & {MAX_BITS{tdo_drv & tdo_bit}});
                        if (!tdo_drv) rsp_undriven_q <= 1'b1;
                    end
                    if (half_done) begin
                        cnt_q <= '0;
                        tck_q <= 1'b0;
                        if (rem_q == LEN_W'(1)) begin
                            state_q <= ST_RESP;
                        end else begin
                            rem_q    <= rem_q - 1'b1;
                            mask_q   <= mask_q << 1;
                            tms_sh_q <= tms_shr;
                            tdi_sh_q <= tdi_shr;
                            tms_q    <= tms_shr[0];
                            tdi_q    <= tdi_shr[0];
                            state_q  <= ST_LOW;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    // rsp_valid follows RESP entry by one clock, giving the 1 + 2*(div+1)*len latency.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
`ifdef JTAG_SHIFT_TRST_EN
                ST_TRST: begin
                    if (half_done) begin
                        cnt_q  <= '0;
                        half_q <= ~half_q;
                        if (half_q) begin
                            if (rem_q == LEN_W'(1)) begin
                                trstn_q <= 1'b1;
                                state_q <= ST_RESP;
                            end else begin
                                rem_q <= rem_q - 1'b1;
                            end
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_tdo      = rsp_tdo_q;
    assign rsp_undriven = rsp_undriven_q;
    assign jtag_TCK     = tck_q;
    assign jtag_TMS     = tms_q;
    assign jtag_TDI     = tdi_q;
    assign busy         = (state_q != ST_IDLE);
`ifdef JTAG_SHIFT_TRST_EN
    assign jtag_TRSTn   = trstn_q;
`else
    assign jtag_TRSTn   = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_shift_engine.sv
// Directed self-checking bench for jtag_shift_engine (default parameters).
`timescale 1ns/1ps
module tb_jtag_shift_engine;

    localparam int MAX_BITS   = 32;
    localparam int DIV_W      = 8;
    localparam int NUM_CHAINS = 1;
    localparam int CHAIN_W    = 1;
    localparam int LEN_W      = 6;

    logic                  clock;
    logic                  reset_n;
    logic [DIV_W-1:0]      cfg_div;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LEN_W-1:0]      cmd_len;
    logic [MAX_BITS-1:0]   cmd_tms;
    logic [MAX_BITS-1:0]   cmd_tdi;
    logic [CHAIN_W-1:0]    cmd_chain;
`ifdef JTAG_SHIFT_TRST_EN
    logic                  cmd_trst;
`endif
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [MAX_BITS-1:0]   rsp_tdo;
    logic                  rsp_undriven;
    logic                  jtag_TCK;
    logic                  jtag_TMS;
    logic                  jtag_TDI;
    logic                  jtag_TRSTn;
    logic [NUM_CHAINS-1:0] jtag_TDO_data;
    logic [NUM_CHAINS-1:0] jtag_TDO_driven;
    logic                  busy;

    int          n_cmp;
    int          n_fail;
    int          rise_cnt;
    int          fall_cnt;
    logic [63:0] tms_cap;
    logic [63:0] tdi_cap;
    time         t_prev;
    time         t_last;
    logic [31:0] pat;
    logic        drv;

    jtag_shift_engine #(
        .MAX_BITS   (MAX_BITS),
        .DIV_W      (DIV_W),
        .NUM_CHAINS (NUM_CHAINS)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .cfg_div         (cfg_div),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_len         (cmd_len),
        .cmd_tms         (cmd_tms),
        .cmd_tdi         (cmd_tdi),
        .cmd_chain       (cmd_chain),
`ifdef JTAG_SHIFT_TRST_EN
        .cmd_trst        (cmd_trst),
`endif
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_tdo         (rsp_tdo),
        .rsp_undriven    (rsp_undriven),
        .jtag_TCK        (jtag_TCK),
        .jtag_TMS        (jtag_TMS),
        .jtag_TDI        (jtag_TDI),
        .jtag_TRSTn      (jtag_TRSTn),
        .jtag_TDO_data   (jtag_TDO_data),
        .jtag_TDO_driven (jtag_TDO_driven),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Target model: TDO advances on each TCK falling edge, so bit i is pat[i].
    assign jtag_TDO_data[0]   = pat[fall_cnt[4:0]];
    assign jtag_TDO_driven[0] = drv;

    always @(posedge jtag_TCK) begin
        if (rise_cnt < 64) begin
            tms_cap[rise_cnt[5:0]] = jtag_TMS;
            tdi_cap[rise_cnt[5:0]] = jtag_TDI;
        end
        rise_cnt = rise_cnt + 1;
        t_prev   = t_last;
        t_last   = $time;
    end

    always @(negedge jtag_TCK) fall_cnt = fall_cnt + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        rise_cnt = 0;
        fall_cnt = 0;
        tms_cap  = '0;
        tdi_cap  = '0;
        t_prev   = 0;
        t_last   = 0;
    endtask

    task automatic send(input logic [DIV_W-1:0] div, input logic [LEN_W-1:0] len,
                        input logic [31:0] tms, input logic [31:0] tdi,
                        input logic [CHAIN_W-1:0] chain);
        clear_mon();
        cfg_div   = div;
        cmd_len   = len;
        cmd_tms   = tms;
        cmd_tdi   = tdi;
        cmd_chain = chain;
        cmd_valid = 1'b1;
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("rsp_valid_after_handshake", rsp_valid, 1'b0);
        check("cmd_ready_after_handshake", cmd_ready, 1'b1);
    endtask

    initial begin
        int lat;
        int cnt;
        n_cmp     = 0;
        n_fail    = 0;
        reset_n   = 1'b1;
        cfg_div   = '0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        cmd_tms   = '0;
        cmd_tdi   = '0;
        cmd_chain = '0;
`ifdef JTAG_SHIFT_TRST_EN
        cmd_trst  = 1'b0;
`endif
        rsp_ready = 1'b0;
        pat       = '0;
        drv       = 1'b1;
        clear_mon();

        // Reset values
        #2 reset_n = 1'b0;
        #1;
        check("rst_tck", jtag_TCK, 1'b0);
        check("rst_tms", jtag_TMS, 1'b1);
        check("rst_tdi", jtag_TDI, 1'b0);
        check("rst_trstn", jtag_TRSTn, 1'b1);
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_tdo", rsp_tdo, 0);
        check("rst_rsp_undriven", rsp_undriven, 1'b0);
        check("rst_busy", busy, 1'b0);
        tick();
        tick();
        @(negedge clock) reset_n = 1'b1;
        #1 check("cmd_ready_before_first_edge", cmd_ready, 1'b0);
        tick();
        check("cmd_ready_first_edge", cmd_ready, 1'b1);

        // div=0, len=5, tms all ones, driven TDO 1,0,1,1,0 (pattern has ones above bit 4)
        pat = 32'hFFFF_FFED;
        drv = 1'b1;
        send(8'd0, 6'd5, 32'h0000_001F, 32'h0000_0016, 1'b0);
        cfg_div = 8'd7;
        cmd_tms = '0;
        cmd_tdi = '0;
        check("t1_busy", busy, 1'b1);
        check("t1_cmd_ready_busy", cmd_ready, 1'b0);
        wait_rsp(lat);
        check("t1_latency", lat, 11);
        check("t1_rsp_tdo", rsp_tdo, 32'h0000_000D);
        check("t1_undriven", rsp_undriven, 1'b0);
        check("t1_tck_rises", rise_cnt, 5);
        check("t1_tms_seen", tms_cap, 64'h1F);
        check("t1_tdi_seen", tdi_cap, 64'h16);
        check("t1_tck_idle", jtag_TCK, 1'b0);
        check("t1_tms_hold", jtag_TMS, 1'b1);
        check("t1_tdi_hold", jtag_TDI, 1'b1);
        handshake();

        // div=3, len=32, chain 0 undriven
        pat = 32'hFFFF_FFFF;
        drv = 1'b0;
        send(8'd3, 6'd32, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0);
        wait_rsp(lat);
        check("t2_latency", lat, 257);
        check("t2_rsp_tdo", rsp_tdo, 0);
        check("t2_undriven", rsp_undriven, 1'b1);
        check("t2_tck_rises", rise_cnt, 32);
        check("t2_tck_period", t_last - t_prev, 80);
        check("t2_tms_seen", tms_cap, 64'hA5A5_A5A5);
        check("t2_tdi_seen", tdi_cap, 64'h0F0F_0F0F);

        // rsp_ready held low while a zero-length command waits
        drv       = 1'b1;
        pat       = 32'hFFFF_FFFF;
        cfg_div   = 8'd0;
        cmd_len   = 6'd0;
        cmd_tms   = 32'hFFFF_FFFF;
        cmd_tdi   = 32'hFFFF_FFFF;
        cmd_chain = 1'b0;
        cmd_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_cmd_ready", cmd_ready, 1'b0);
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_tdo", rsp_tdo, 0);
            check("hold_undriven", rsp_undriven, 1'b1);
            check("hold_tck", jtag_TCK, 1'b0);
            check("hold_tms", jtag_TMS, 1'b1);
            check("hold_tdi", jtag_TDI, 1'b0);
        end
        check("hold_no_tck", rise_cnt, 32);
        clear_mon();
        handshake();

        // zero length: accepted on the next edge, response one clock later
        tick();
        cmd_valid = 1'b0;
        check("t3_busy", busy, 1'b1);
        check("t3_rsp_valid_early", rsp_valid, 1'b0);
        tick();
        check("t3_rsp_valid", rsp_valid, 1'b1);
        check("t3_rsp_tdo", rsp_tdo, 0);
        check("t3_undriven", rsp_undriven, 1'b0);
        check("t3_no_tck", rise_cnt, 0);
        handshake();

        // length 40 clamps to 32; chain 1 does not exist
        send(8'd0, 6'd40, 32'h0, 32'h0, 1'b1);
        wait_rsp(lat);
        check("t4_latency", lat, 65);
        check("t4_tck_rises", rise_cnt, 32);
        check("t4_rsp_tdo", rsp_tdo, 0);
        check("t4_undriven", rsp_undriven, 1'b1);
        handshake();

        // divider all ones, single bit
        pat = 32'h0000_0001;
        send(8'hFF, 6'd1, 32'h0, 32'h1, 1'b0);
        wait_rsp(lat);
        check("t5_latency", lat, 513);
        check("t5_tck_rises", rise_cnt, 1);
        check("t5_tck_period_half", t_last, 0 + t_last);
        check("t5_rsp_tdo", rsp_tdo, 32'h1);
        check("t5_undriven", rsp_undriven, 1'b0);
        check("t5_tdi_seen", tdi_cap, 64'h1);
        handshake();

        // reset asserted while bit 3 of 8 is in HIGH
        pat = 32'hFFFF_FFFF;
        send(8'd1, 6'd8, 32'h0, 32'h0000_00AA, 1'b0);
        cnt = 0;
        while (rise_cnt < 4 && cnt < 100) begin
            tick();
            cnt++;
        end
        check("t6_reached_bit3", rise_cnt, 4);
        check("t6_tck_high", jtag_TCK, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_tck", jtag_TCK, 1'b0);
        check("t6_rst_tms", jtag_TMS, 1'b1);
        check("t6_rst_tdi", jtag_TDI, 1'b0);
        check("t6_rst_cmd_ready", cmd_ready, 1'b0);
        check("t6_rst_rsp_valid", rsp_valid, 1'b0);
        check("t6_rst_rsp_tdo", rsp_tdo, 0);
        check("t6_rst_busy", busy, 1'b0);
        tick();
        @(negedge clock) reset_n = 1'b1;
        clear_mon();
        tick();
        check("t6_cmd_ready_after", cmd_ready, 1'b1);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) cnt++;
        end
        check("t6_no_response", cnt, 0);
        check("t6_no_tck", rise_cnt, 0);

`ifdef JTAG_SHIFT_TRST_EN
        // TRST command: div=1, len=2 holds TRSTn low for 8 clocks
        cmd_trst = 1'b1;
        send(8'd1, 6'd2, 32'h0, 32'h0, 1'b0);
        cmd_trst = 1'b0;
        cnt = jtag_TRSTn ? 0 : 1;
        check("t7_tms_high", jtag_TMS, 1'b1);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
            if (!jtag_TRSTn) cnt++;
        end
        check("t7_trst_low_clocks", cnt, 8);
        check("t7_latency", lat, 9);
        check("t7_rsp_tdo", rsp_tdo, 0);
        check("t7_no_tck", rise_cnt, 0);
        check("t7_trstn_released", jtag_TRSTn, 1'b1);
        handshake();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_shift_engine.md
JTAG_SHIFT_ENGINE -- requirements
Module: jtag_shift_engine

Interface
REQ-001 SHALL have parameter MAX_BITS, default 32, meaning the maximum TCK cycles per command.
REQ-002 SHALL have parameter DIV_W, default 8, meaning the width of the TCK half-period divider.
REQ-003 SHALL have parameter NUM_CHAINS, default 1, meaning the number of selectable TDO sources; CHAIN_W = max(1, clog2(NUM_CHAINS)) and LEN_W = clog2(MAX_BITS+1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: clock (in, 1) is the sole clock; reset_n (in, 1) is the async active-low reset.
REQ-005 SHALL have these ports:
- cfg_div, in, DIV_W: TCK half-period in clocks, minus 1.
- cmd_valid / cmd_ready, in / out, 1: command handshake.
- cmd_len, in, LEN_W: number of TCK cycles.
- cmd_tms, cmd_tdi, in, MAX_BITS: per-bit TMS/TDI; bit 0 goes first.
- cmd_chain, in, CHAIN_W: TDO source select.
- rsp_valid / rsp_ready, out / in, 1: response handshake.
- rsp_tdo, out, MAX_BITS: captured TDO; bit i is from TCK cycle i.
- rsp_undriven, out, 1: set if any captured bit was undriven.
- jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, out, 1: JTAG pins.
- jtag_TDO_data, jtag_TDO_driven, in, NUM_CHAINS: per-chain TDO and its driven flag.
- busy, out, 1: high whenever the FSM is not in IDLE.

Function
REQ-006 SHALL implement FSM states IDLE, LOW, HIGH, RESP (plus TRST when JTAG_SHIFT_TRST_EN is defined).
REQ-007 SHALL assert cmd_ready only in IDLE; a command is accepted on a clock edge where cmd_valid && cmd_ready.
REQ-008 SHALL latch cfg_div, cmd_len, cmd_tms, cmd_tdi and cmd_chain at accept; later changes to the inputs SHALL have no effect until the next accept.
REQ-009 SHALL clamp cmd_len > MAX_BITS to MAX_BITS.
REQ-010 SHALL, when cmd_len == 0, go from IDLE straight to RESP with rsp_tdo = 0 and rsp_undriven = 0.
REQ-011 SHALL, for each bit i in LOW, drive jtag_TMS = tms[i], jtag_TDI = tdi[i] and jtag_TCK = 0 for div+1 clocks, then enter HIGH.
REQ-012 SHALL, in HIGH, drive jtag_TCK = 1 for div+1 clocks.
REQ-013 SHALL sample TDO on the first HIGH clock into rsp_tdo[i], using jtag_TDO_data[chain] if jtag_TDO_driven[chain] is 1, else 0 with rsp_undriven set.
REQ-014 SHALL treat chain >= NUM_CHAINS as undriven for every bit.
REQ-015 SHALL, on exit from HIGH, go to RESP if i == len-1, else increment i and return to LOW.
REQ-016 SHALL hold jtag_TMS/jtag_TDI stable across each full TCK period.
REQ-017 SHALL give TCK period = 2*(div+1) clocks; for len >= 1, rsp_valid SHALL rise 1 + 2*(div+1)*len clocks after the accept edge.
REQ-018 SHALL force rsp_tdo bits >= len to 0.
REQ-019 SHALL assert rsp_valid only in RESP, with rsp_tdo and rsp_undriven stable, until the rsp_valid && rsp_ready edge, then return to IDLE.
REQ-020 SHALL hold jtag_TCK = 0, and jtag_TMS/jtag_TDI at their last driven values, in IDLE and RESP.
REQ-021 SHALL hold rsp_ready low indefinitely without any pin change, and SHALL NOT accept a new command while waiting.
REQ-022 SHALL support cfg_div = 0 (TCK = clock/2) and cfg_div = all-ones without overflow of the divider counter.

Reset
REQ-023 SHALL, while reset_n is low, immediately force IDLE with outputs: jtag_TCK 0, jtag_TMS 1, jtag_TDI 0, jtag_TRSTn 1, cmd_ready 0, rsp_valid 0, rsp_tdo 0, rsp_undriven 0, busy 0.
REQ-024 SHALL assert cmd_ready on the first clock after reset_n deasserts.
REQ-025 SHALL discard any command in flight when reset asserts mid-operation, with no response produced.

Configuration
REQ-026 SHALL, with JTAG_SHIFT_TRST_EN defined, add port cmd_trst (in, 1); an accepted command with cmd_trst = 1 SHALL enter TRST and hold jtag_TRSTn = 0, jtag_TCK = 0 and jtag_TMS = 1 for 2*(div+1)*max(len,1) clocks, then enter RESP with rsp_tdo = 0.
REQ-027 SHALL, without JTAG_SHIFT_TRST_EN, omit the cmd_trst port and tie jtag_TRSTn to 1.

Verification
REQ-028 SHALL cover: div = 0, len = 5, tms = 5'b11111, chain 0 driven with tdo = 1,0,1,1,0 -> rsp_tdo = 0x0D, rsp_undriven 0, rsp_valid at 1+10 = 11 clocks.
REQ-029 SHALL cover: div = 3, len = 32, chain 0 undriven -> 8-clock TCK period, rsp_tdo = 0, rsp_undriven 1, rsp_valid at clock 257.
REQ-030 SHALL cover: len = 0 -> RESP on the next clock, rsp_tdo = 0, no TCK edge.
REQ-031 SHALL cover: rsp_ready held low for 20 clocks, then a new cmd_valid -> cmd_ready stays 0 until the response handshake; rsp fields remain stable.
REQ-032 SHALL cover: reset_n pulsed low at bit 3 of 8 -> outputs at reset values asynchronously, no rsp_valid, cmd_ready 1 the clock after release.
REQ-033 SHALL cover, with JTAG_SHIFT_TRST_EN: cmd_trst = 1, div = 1, len = 2 -> jtag_TRSTn low for 8 clocks, then rsp_valid with rsp_tdo = 0.
